// File: rtl/level_pkg.sv
// Shared level definitions: background tile codes, grid size, tile coordinate types
// and the coin bookkeeping FSM states.
package level_pkg;

  typedef logic [4:0] tile_col_t;
  typedef logic [3:0] tile_row_t;
  typedef logic [7:0] tile_t;

  localparam tile_t BDR = 8'd0;
  localparam tile_t SKY = 8'd1;
  localparam tile_t BLK = 8'd2;
  localparam tile_t GND = 8'd3;
  localparam tile_t TKN = 8'd4;
  localparam tile_t CK1 = 8'd5;
  localparam tile_t CK2 = 8'd6;

  localparam int GRID_COLS = 17;
  localparam int GRID_ROWS = 12;

  typedef enum logic [1:0] {
    RESTORE,
    SCAN,
    CLEAR,
    DONE
  } coin_state_e;

endpackage

// File: rtl/coin_overlap.sv
// Combinational strict-overlap test between Mario's square box and one tile box.
// Signed 32-bit arithmetic; boxes that only share an edge do not overlap.
module coin_overlap
  import level_pkg::*;
#(
  parameter int BLOCK_WIDTH     = 40,
  parameter int CHARACTER_WIDTH = 42
) (
  input  tile_col_t          tile_x,
  input  tile_row_t          tile_y,
  input  logic signed [31:0] mario_x,
  input  logic signed [31:0] mario_y,
  output logic               hit
);

  int left;
  int top;

  always_comb begin
    left = int'({27'd0, tile_x}) * BLOCK_WIDTH;
    top  = int'({28'd0, tile_y}) * BLOCK_WIDTH;
    hit  = (mario_x < left + BLOCK_WIDTH) && (mario_x + CHARACTER_WIDTH > left) &&
           (mario_y < top + BLOCK_WIDTH)  && (mario_y + CHARACTER_WIDTH > top);
  end

endmodule

// File: rtl/coin_tracker.sv
// Coin bookkeeping: restores coin tiles, scans one coin per cycle for Mario hits, clears them.
// Hit state updates on the SCAN edge; each write holds wr_valid until wr_ready, stalling the scan.
module coin_tracker
  import level_pkg::*;
#(
  parameter int                   NUM_COINS       = 2,
  parameter int                   WIN_COUNT       = NUM_COINS,
  parameter logic [5*NUM_COINS-1:0] COIN_X        = '0,
  parameter logic [4*NUM_COINS-1:0] COIN_Y        = '0,
  parameter tile_t                SKY             = level_pkg::SKY,
  parameter tile_t                TKN             = level_pkg::TKN,
  parameter int                   CHARACTER_WIDTH = 42,
  parameter int                   BLOCK_WIDTH     = 40
) (
  input  logic                               vga_clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic signed [31:0]                 mario_x,
  input  logic signed [31:0]                 mario_y,
  output logic                               wr_valid,
  input  logic                               wr_ready,
  output tile_col_t                          wr_x,
  output tile_row_t                          wr_y,
  output tile_t                              wr_tile,
  output logic [NUM_COINS-1:0]               collected,
  output logic [$clog2(NUM_COINS+1)-1:0]     coins_left,
  output logic                               coin_pulse,
  output logic                               win,
  output logic                               busy
);

  localparam int IW = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
  localparam int CW = $clog2(NUM_COINS + 1);

  coin_state_e   state, state_n;
  logic [IW-1:0] idx, idx_inc;
  logic          armed, last, overlap, hit;
  logic [CW-1:0] taken_n;
  tile_col_t     cur_x, clr_x;
  tile_row_t     cur_y, clr_y;
  tile_col_t     coin_x_arr [NUM_COINS];
  tile_row_t     coin_y_arr [NUM_COINS];

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_coin
    assign coin_x_arr[g] = COIN_X[5*g +: 5];
    assign coin_y_arr[g] = COIN_Y[4*g +: 4];
  end

  assign cur_x   = coin_x_arr[idx];
  assign cur_y   = coin_y_arr[idx];
  assign last    = (idx == IW'(NUM_COINS - 1));
  assign idx_inc = last ? '0 : idx + IW'(1);
  assign taken_n = CW'(NUM_COINS) - coins_left + CW'(1);
  assign hit     = (state == SCAN) && enable && !collected[idx] && overlap && (coins_left != '0);

  coin_overlap #(
    .BLOCK_WIDTH    (BLOCK_WIDTH),
    .CHARACTER_WIDTH(CHARACTER_WIDTH)
  ) u_overlap (
    .tile_x (cur_x),
    .tile_y (cur_y),
    .mario_x(mario_x),
    .mario_y(mario_y),
    .hit    (overlap)
  );

  // armed keeps wr_valid low through reset and for the first cycle after release.
  always_comb begin
    state_n  = state;
    wr_valid = 1'b0;
    wr_x     = clr_x;
    wr_y     = clr_y;
    wr_tile  = SKY;
    busy     = 1'b0;
    case (state)
      RESTORE: begin
        busy     = 1'b1;
        wr_valid = armed;
        wr_x     = cur_x;
        wr_y     = cur_y;
        wr_tile  = TKN;
        if (armed && wr_ready && last) state_n = SCAN;
      end
      SCAN:  if (hit) state_n = CLEAR;
      CLEAR: begin
        wr_valid = 1'b1;
        if (wr_ready) state_n = win ? DONE : SCAN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      state      <= RESTORE;
      idx        <= '0;
      collected  <= '0;
      coins_left <= CW'(NUM_COINS);
      coin_pulse <= 1'b0;
      win        <= 1'b0;
      armed      <= 1'b0;
      clr_x      <= '0;
      clr_y      <= '0;
    end else begin
      state      <= state_n;
      armed      <= 1'b1;
      coin_pulse <= 1'b0;
      case (state)
        RESTORE: if (armed && wr_ready) idx <= idx_inc;
        SCAN: begin
          if (hit) begin
            collected[idx] <= 1'b1;
            coins_left     <= coins_left - CW'(1);
            coin_pulse     <= 1'b1;
            clr_x          <= cur_x;
            clr_y          <= cur_y;
            if (taken_n >= CW'(WIN_COUNT)) win <= 1'b1;
          end else begin
            idx <= idx_inc;
          end
        end
        CLEAR: if (wr_ready) idx <= idx_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_tracker.sv
// Scoreboard bench for coin_tracker: 3 coins at tiles (2,1), (6,2), (3,1); win after 2 coins.
module tb_coin_tracker;
  import level_pkg::*;

  localparam int N = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b1;
  logic               wr_ready = 1'b1;
  logic signed [31:0] mario_x = 600;
  logic signed [31:0] mario_y = 400;
  logic               wr_valid;
  tile_col_t          wr_x;
  tile_row_t          wr_y;
  tile_t              wr_tile;
  logic [N-1:0]       collected;
  logic [1:0]         coins_left;
  logic               coin_pulse, win, busy;

  int          n_vec = 0;
  int          n_err = 0;
  int          pulse_cnt = 0;
  logic [16:0] exp_q[$];
  logic [16:0] sb_e;

  always #5 clk = ~clk;

  coin_tracker #(
    .NUM_COINS(N),
    .WIN_COUNT(2),
    .COIN_X   (15'({5'd3, 5'd6, 5'd2})),
    .COIN_Y   (12'({4'd1, 4'd2, 4'd1}))
  ) dut (
    .vga_clock (clk),
    .reset     (reset),
    .enable    (enable),
    .mario_x   (mario_x),
    .mario_y   (mario_y),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_tile   (wr_tile),
    .collected (collected),
    .coins_left(coins_left),
    .coin_pulse(coin_pulse),
    .win       (win),
    .busy      (busy)
  );

  // Monitor samples after the testbench drives (negedge+1), well before the next posedge.
  always @(negedge clk) begin
    #2;
    if (coin_pulse === 1'b1) pulse_cnt++;
    if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_write: unexpected write x=%0d y=%0d tile=%0d", wr_x, wr_y, wr_tile);
      end else begin
        sb_e = exp_q.pop_front();
        if ({wr_x, wr_y, wr_tile} !== sb_e) begin
          n_err++;
          $display("FAIL sb_write: got x=%0d y=%0d tile=%0d, want x=%0d y=%0d tile=%0d",
                   wr_x, wr_y, wr_tile, sb_e[16:12], sb_e[11:8], sb_e[7:0]);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_tkn_all();
    exp_q.push_back({5'd2, 4'd1, TKN});
    exp_q.push_back({5'd6, 4'd2, TKN});
    exp_q.push_back({5'd3, 4'd1, TKN});
  endtask

  // Reset with Mario parked at (x,y) and wait for the three restore writes to drain.
  task automatic restart(input int x, input int y);
    bit ok = 0;
    wr_ready = 1'b1;
    reset    = 1'b1;
    mario_x  = x;
    mario_y  = y;
    tick();
    tick();
    exp_q.delete();
    push_tkn_all();
    reset = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (exp_q.size() == 0) ok = 1;
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL restore_drain: %0d writes pending, want 0", exp_q.size());
    end
  endtask

  // Bounded wait for coin_pulse; returns 1 if seen.
  task automatic wait_pulse(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (coin_pulse === 1'b1) seen = 1;
    end
  endtask

  task automatic test_reset();
    tick();
    n_vec += 6;
    if (wr_valid !== 1'b0) begin n_err++; $display("FAIL rst_wr_valid: got %b want 0", wr_valid); end
    if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b want 1", busy); end
    if (coins_left !== 2'd3) begin n_err++; $display("FAIL rst_coins_left: got %0d want 3", coins_left); end
    if (collected !== 3'b000) begin n_err++; $display("FAIL rst_collected: got %b want 000", collected); end
    if (win !== 1'b0) begin n_err++; $display("FAIL rst_win: got %b want 0", win); end
    if (coin_pulse !== 1'b0) begin n_err++; $display("FAIL rst_pulse: got %b want 0", coin_pulse); end
    push_tkn_all();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (wr_valid !== 1'b1 || wr_tile !== TKN || busy !== 1'b1) begin
        n_err++;
        $display("FAIL restore_cycle%0d: valid=%b tile=%0d busy=%b want 1/%0d/1", i, wr_valid, wr_tile, busy, TKN);
      end
    end
    tick();
    n_vec += 3;
    if (busy !== 1'b0) begin n_err++; $display("FAIL restore_busy_end: got %b want 0", busy); end
    if (coins_left !== 2'd3) begin n_err++; $display("FAIL restore_coins_left: got %0d want 3", coins_left); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL restore_writes: %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_single();
    bit seen;
    int base = pulse_cnt;
    exp_q.push_back({5'd6, 4'd2, SKY});
    mario_x = 240;
    mario_y = 80;
    wait_pulse(10, seen);
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL single_pulse: timeout, no pulse in 10 cycles"); end
    n_vec += 3;
    if (collected !== 3'b010) begin n_err++; $display("FAIL single_collected: got %b want 010", collected); end
    if (coins_left !== 2'd2) begin n_err++; $display("FAIL single_coins_left: got %0d want 2", coins_left); end
    if (win !== 1'b0) begin n_err++; $display("FAIL single_win: got %b want 0", win); end
    repeat (20) tick();
    n_vec += 2;
    if (pulse_cnt - base !== 1) begin n_err++; $display("FAIL single_pulse_count: got %0d want 1", pulse_cnt - base); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL single_sky_write: %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_win();
    bit seen;
    bit any_valid = 0;
    int base;
    exp_q.push_back({5'd2, 4'd1, SKY});
    mario_x = 70;
    mario_y = 40;
    wait_pulse(10, seen);
    n_vec += 4;
    if (!seen) begin n_err++; $display("FAIL win_pulse: timeout, no pulse in 10 cycles"); end
    if (win !== 1'b1) begin n_err++; $display("FAIL win_on_hit: got %b want 1", win); end
    if (coins_left !== 2'd1) begin n_err++; $display("FAIL win_coins_left: got %0d want 1", coins_left); end
    if (collected !== 3'b011) begin n_err++; $display("FAIL win_collected: got %b want 011", collected); end
    tick();
    base = pulse_cnt;
    mario_x = 130;
    mario_y = 40;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_valid !== 1'b0) any_valid = 1;
    end
    n_vec += 4;
    if (any_valid) begin n_err++; $display("FAIL done_wr_valid: got 1 want 0"); end
    if (pulse_cnt - base !== 0) begin n_err++; $display("FAIL done_no_pulse: got %0d want 0", pulse_cnt - base); end
    if (coins_left !== 2'd1) begin n_err++; $display("FAIL done_coins_left: got %0d want 1", coins_left); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL win_sky_write: %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [4:0] want_x [2];
    bit ok;
    want_x[0] = 5'd2;
    want_x[1] = 5'd3;
    restart(100, 40);
    base = pulse_cnt;
    wr_ready = 1'b0;
    exp_q.push_back({5'd2, 4'd1, SKY});
    exp_q.push_back({5'd3, 4'd1, SKY});
    for (int c = 0; c < 2; c++) begin
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
        tick();
        if (wr_valid === 1'b1) ok = 1;
      end
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL b2b_clear%0d: timeout waiting wr_valid", c); end
      for (int s = 0; s < 5; s++) begin
        n_vec++;
        if (wr_valid !== 1'b1 || wr_x !== want_x[c] || wr_y !== 4'd1 || wr_tile !== SKY) begin
          n_err++;
          $display("FAIL b2b_stall%0d_%0d: valid=%b x=%0d y=%0d tile=%0d want 1/%0d/1/%0d",
                   c, s, wr_valid, wr_x, wr_y, wr_tile, want_x[c], SKY);
        end
        tick();
      end
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
    end
    repeat (3) tick();
    n_vec += 4;
    if (coins_left !== 2'd1) begin n_err++; $display("FAIL b2b_coins_left: got %0d want 1", coins_left); end
    if (collected !== 3'b101) begin n_err++; $display("FAIL b2b_collected: got %b want 101", collected); end
    if (pulse_cnt - base !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d want 2", pulse_cnt - base); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_writes: %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_enable();
    int  base;
    bit  seen;
    bit  any_valid = 0;
    enable = 1'b0;
    restart(240, 80);
    base = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr_valid !== 1'b0) any_valid = 1;
    end
    tick();
    n_vec += 2;
    if (pulse_cnt - base !== 0) begin n_err++; $display("FAIL enable_low_pulse: got %0d want 0", pulse_cnt - base); end
    if (any_valid) begin n_err++; $display("FAIL enable_low_write: got write want none"); end
    wr_ready = 1'b0;
    exp_q.push_back({5'd6, 4'd2, SKY});
    enable = 1'b1;
    wait_pulse(N + 1, seen);
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL enable_high_pulse: timeout, no pulse in %0d cycles", N + 1); end
  endtask

  task automatic test_reset_mid_clear();
    tick();
    tick();
    n_vec++;
    if (wr_valid !== 1'b1) begin n_err++; $display("FAIL midclr_pending: wr_valid got %b want 1", wr_valid); end
    reset = 1'b1;
    #1;
    n_vec += 4;
    if (wr_valid !== 1'b0) begin n_err++; $display("FAIL midclr_drop: wr_valid got %b want 0", wr_valid); end
    if (busy !== 1'b1) begin n_err++; $display("FAIL midclr_busy: got %b want 1", busy); end
    if (coins_left !== 2'd3) begin n_err++; $display("FAIL midclr_coins_left: got %0d want 3", coins_left); end
    if (collected !== 3'b000) begin n_err++; $display("FAIL midclr_collected: got %b want 000", collected); end
    exp_q.delete();
    restart(600, 400);
    tick();
    n_vec += 2;
    if (busy !== 1'b0) begin n_err++; $display("FAIL midclr_restore_busy: got %b want 0", busy); end
    if (win !== 1'b0) begin n_err++; $display("FAIL midclr_win: got %b want 0", win); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_win();
    test_back_to_back();
    test_enable();
    test_reset_mid_clear();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coin_tracker.md
# coin_tracker

Parametrised coin bookkeeping for a level: holds NUM_COINS coin tile positions, detects Mario touching each uncollected coin, and issues tile-write requests to the level's background map. Writes SKY on collection and TKN on restore. Counts collected and remaining coins and raises `win` at a configurable target. It sits between the Mario mover and the level's background storage, and replaces per-coin instances plus hand-written clear logic.

## Interface
Parameters:
- `NUM_COINS`, 2, number of coins (1..32)
- `WIN_COUNT`, NUM_COINS, collected count that asserts `win` (1..NUM_COINS)
- `COIN_X`, all zero, packed NUM_COINS×5-bit tile columns; entry i at bits [5i+4:5i]
- `COIN_Y`, all zero, packed NUM_COINS×4-bit tile rows; entry i at bits [4i+3:4i]
- `SKY`, 1, tile code written on collection
- `TKN`, 4, tile code written on restore
- `CHARACTER_WIDTH`, 42, Mario box size in pixels (square)
- `BLOCK_WIDTH`, 40, tile size in pixels

Ports:
- `vga_clock`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  detection allowed; the level drives 0 once lost
- `mario_x`  in  32 (int)  Mario top-left x, level pixels
- `mario_y`  in  32 (int)  Mario top-left y, level pixels
- `wr_valid`  out  1  tile write request
- `wr_ready`  in  1  background owner accepts the write
- `wr_x`  out  5  tile column
- `wr_y`  out  4  tile row
- `wr_tile`  out  8  tile code (SKY or TKN)
- `collected`  out  NUM_COINS  per-coin collected mask
- `coins_left`  out  CW=$clog2(NUM_COINS+1)  remaining coins
- `coin_pulse`  out  1  one-cycle pulse per collection
- `win`  out  1  level, sticky until reset
- `busy`  out  1  high in RESTORE

## Operation
- Coin i box: x in [COIN_X[i]·BLOCK_WIDTH, +BLOCK_WIDTH), y in [COIN_Y[i]·BLOCK_WIDTH, +BLOCK_WIDTH).
- Overlap test: mario_x < left+BLOCK_WIDTH, mario_x+CHARACTER_WIDTH > left, and the same for y. All arithmetic is signed 32-bit. Edge-touching does not count.
- Index `idx`, width max(1,$clog2(NUM_COINS)), wraps from NUM_COINS-1 to 0.
- FSM states:
  - RESTORE: drive wr_valid=1, wr_tile=TKN, wr_x/wr_y from coin idx. On wr_ready, advance idx. After coin NUM_COINS-1 is accepted, set idx=0 and go to SCAN.
  - SCAN: each cycle, test coin idx.
    - Hit (enable, not collected[idx], overlap): in the same edge, set collected[idx], decrement coins_left, pulse coin_pulse, and load wr_x/wr_y/wr_tile=SKY. Go to CLEAR.
    - Otherwise: idx+1.
  - CLEAR: hold wr_valid=1 with stable wr_x/wr_y/wr_tile until wr_ready. Then idx+1. Go to DONE if win, else SCAN.
  - DONE: wr_valid=0. No further detection. Outputs are frozen.
- win: registered. Set on the edge where collected count (NUM_COINS − coins_left) reaches WIN_COUNT.
- Simultaneous touches on several coins: serialised, one per visit in idx order, each getting its own CLEAR.
- enable low: blocks new hits only. A CLEAR already in progress completes.
- A coin already collected is never re-counted. coins_left never underflows.

## Timing
- Reset values, asserted asynchronously:
  - state=RESTORE, idx=0, collected=0, coins_left=NUM_COINS
  - coin_pulse=0, win=0
  - wr_valid=0 while reset is high; busy=1
- First RESTORE write: wr_valid rises the cycle after reset deasserts.
- RESTORE lasts at least NUM_COINS cycles (one per write when wr_ready=1).
- Detection latency: at most NUM_COINS cycles from overlap start to coin_pulse, plus any CLEAR stall.
- Timing from hit edge (SCAN → CLEAR):
  - Same edge: coin_pulse, coins_left and collected update.
  - Next cycle: wr_valid is high.
- Handshake: a write completes on a cycle with wr_valid & wr_ready. wr_valid never drops without acceptance except on reset.
- Reset mid-CLEAR: the pending write is abandoned. RESTORE re-writes TKN to every coin.

## Structure
- `level_pkg` holds:
  - tile codes BDR/SKY/BLK/GND/TKN/CK1/CK2
  - grid dimensions 17×12
  - typedefs `tile_col_t` (5 bits), `tile_row_t` (4 bits), `tile_t` (byte)
  - FSM enum `coin_state_e`
- Sub-module `coin_overlap`: combinational box test taking tile x/y and mario x/y, with parameters BLOCK_WIDTH and CHARACTER_WIDTH. One instance fed by the idx mux.

## Test plan
- Reset release, NUM_COINS=3, wr_ready=1 → three TKN writes at the coin coordinates on consecutive cycles, then busy=0, coins_left=3.
- Mario placed over coin 1 (e.g., x=240, y=80 for tile (6,2) with BLOCK_WIDTH=40) → one coin_pulse, collected=3'b010, a SKY write to (6,2), and no second pulse while Mario stays there.
- Mario overlaps coins 0 and 2 simultaneously, wr_ready held low 5 cycles → two CLEARs in idx order, wr_x/wr_y stable during each stall, coins_left=1.
- WIN_COUNT=2 of 3: collect two coins → win rises on the second hit edge, the FSM enters DONE after acceptance, and touching coin 3 gives no pulse.
- enable=0 while overlapping → no pulse; enable=1 → pulse within NUM_COINS cycles.
- reset asserted while wr_valid is high in CLEAR → wr_valid drops immediately, and RESTORE rewrites all coins after release.
